// File: rtl/lsc_gain_gen.sv
// lsc_gain_gen: per-pixel radial lens-shading gain lookup; `LSC_GAIN_BYPASS_EN adds a gain_bypass input forcing unity gains
module lsc_gain_gen #(
    parameter int DATA_WIDTH = 12,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int LUT_DEPTH  = 64,
    parameter int R2_SHIFT   = 12
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          u_i_ready,
    input  logic                          u_r_ready,
    input  logic                          sof,
    input  logic [3*DATA_WIDTH-1:0]       data_in,
    input  logic [$clog2(IMG_W)-1:0]      cx,
    input  logic [$clog2(IMG_H)-1:0]      cy,
    input  logic                          lut_we,
    input  logic [$clog2(LUT_DEPTH)-1:0]  lut_addr,
    input  logic [3*DATA_WIDTH-1:0]       lut_data,
`ifdef LSC_GAIN_BYPASS_EN
    input  logic                          gain_bypass,
`endif
    output logic [3*DATA_WIDTH-1:0]       data_out,
    output logic [3*DATA_WIDTH-1:0]       gain_out,
    output logic                          eof,
    output logic                          i_i_ready,
    output logic                          i_r_ready
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int RW = 2*XW+1;
    localparam int AW = $clog2(LUT_DEPTH);
    localparam int GW = 3*DATA_WIDTH;
    localparam logic [GW-1:0] UNITY = {3{DATA_WIDTH'(256)}};
    logic [XW-1:0] x, px, nx, dx;
    logic [YW-1:0] y, py, ny, dy;
    logic [RW-1:0] r2, r2s;
    logic [AW-1:0] idx;
    logic [GW-1:0] lut [LUT_DEPTH];
    logic [GW-1:0] gain;
    logic accept, x_end, last;
    assign accept = u_i_ready & i_i_ready;
    // sof re-anchors the accepted pixel to the frame origin
    assign px = sof ? '0 : x;
    assign py = sof ? '0 : y;
    assign x_end = px == XW'(IMG_W-1);
    assign last = x_end && py == YW'(IMG_H-1);
    assign nx = x_end ? '0 : px + 1'b1;
    assign ny = !x_end ? py : last ? '0 : py + 1'b1;
    assign dx = px > cx ? px - cx : cx - px;
    assign dy = py > cy ? py - cy : cy - py;
    assign r2 = RW'(dx) * RW'(dx) + RW'(dy) * RW'(dy);
    assign r2s = r2 >> R2_SHIFT;
    assign idx = 32'(r2s) > 32'(LUT_DEPTH-1) ? AW'(LUT_DEPTH-1) : AW'(r2s);
`ifdef LSC_GAIN_BYPASS_EN
    assign gain = gain_bypass ? UNITY : lut[idx];
`else
    assign gain = lut[idx];
`endif
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            x         <= '0;
            y         <= '0;
            data_out  <= '0;
            gain_out  <= '0;
            eof       <= 1'b0;
            i_i_ready <= 1'b1;
            i_r_ready <= 1'b0;
        end else if (accept) begin
            x         <= nx;
            y         <= ny;
            data_out  <= data_in;
            gain_out  <= gain;
            eof       <= last;
            i_i_ready <= 1'b0;
            i_r_ready <= 1'b1;
        end else if (i_r_ready & u_r_ready) begin
            i_r_ready <= 1'b0;
            i_i_ready <= 1'b1;
        end
    // a write landing with an accept is only seen by later pixels
    always_ff @(posedge clock or posedge reset)
        if (reset)
            for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= UNITY;
        else if (lut_we)
            lut[lut_addr] <= lut_data;
endmodule

// File: tb/tb_lsc_gain_gen.sv
// tb_lsc_gain_gen: 4x2 frame instance for raster/handshake corners, full-size instance for radial lookup and a random model run
module tb_lsc_gain_gen;
    localparam int GW = 36;
    localparam logic [GW-1:0] UNITY = {12'h100, 12'h100, 12'h100};
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;
    int n_cmp = 0;
    int n_err = 0;

    logic s_ui = 0, s_ur = 0, s_sof = 0, s_we = 0;
    logic [GW-1:0] s_din = '0, s_ldata = '0;
    logic [1:0] s_cx = '0;
    logic [0:0] s_cy = '0;
    logic [5:0] s_addr = '0;
    logic [GW-1:0] s_dout, s_gout;
    logic s_eof, s_ii, s_ir;

    logic d_ui = 0, d_ur = 0, d_sof = 0, d_we = 0;
    logic [GW-1:0] d_din = '0, d_ldata = '0;
    logic [9:0] d_cx = '0;
    logic [8:0] d_cy = '0;
    logic [5:0] d_addr = '0;
    logic [GW-1:0] d_dout, d_gout;
    logic d_eof, d_ii, d_ir;

    lsc_gain_gen #(.IMG_W(4), .IMG_H(2), .R2_SHIFT(0)) dut_s (
        .clock(clock), .reset(reset), .u_i_ready(s_ui), .u_r_ready(s_ur), .sof(s_sof),
        .data_in(s_din), .cx(s_cx), .cy(s_cy), .lut_we(s_we), .lut_addr(s_addr), .lut_data(s_ldata),
`ifdef LSC_GAIN_BYPASS_EN
        .gain_bypass(1'b0),
`endif
        .data_out(s_dout), .gain_out(s_gout), .eof(s_eof), .i_i_ready(s_ii), .i_r_ready(s_ir));

    lsc_gain_gen dut_d (
        .clock(clock), .reset(reset), .u_i_ready(d_ui), .u_r_ready(d_ur), .sof(d_sof),
        .data_in(d_din), .cx(d_cx), .cy(d_cy), .lut_we(d_we), .lut_addr(d_addr), .lut_data(d_ldata),
`ifdef LSC_GAIN_BYPASS_EN
        .gain_bypass(1'b0),
`endif
        .data_out(d_dout), .gain_out(d_gout), .eof(d_eof), .i_i_ready(d_ii), .i_r_ready(d_ir));

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [GW-1:0] s_pat(input int k);
        return {12'(k), 12'(k + 64), 12'(k + 128)};
    endfunction

    task automatic s_push(input logic sof, input logic [GW-1:0] din, input logic [GW-1:0] eg,
                          input logic ee, input string nm);
        s_ui = 1; s_sof = sof; s_din = din;
        tick;
        s_ui = 0; s_sof = 0;
        check({nm, " hs"}, 64'({s_ii, s_ir}), 64'(2'b01));
        check({nm, " data"}, 64'(s_dout), 64'(din));
        check({nm, " gain"}, 64'(s_gout), 64'(eg));
        check({nm, " eof"}, 64'(s_eof), 64'(ee));
        s_ur = 1;
        tick;
        s_ur = 0;
        check({nm, " drain"}, 64'({s_ii, s_ir}), 64'(2'b10));
    endtask

    task automatic d_push(input logic [GW-1:0] din, input logic [GW-1:0] eg, input string nm);
        d_ui = 1; d_din = din;
        tick;
        d_ui = 0;
        check({nm, " hs"}, 64'({d_ii, d_ir}), 64'(2'b01));
        check({nm, " data"}, 64'(d_dout), 64'(din));
        check({nm, " gain"}, 64'(d_gout), 64'(eg));
        d_ur = 1;
        tick;
        d_ur = 0;
    endtask

    task automatic d_write(input int a, input logic [GW-1:0] v);
        d_we = 1; d_addr = 6'(a); d_ldata = v;
        tick;
        d_we = 0;
    endtask

    typedef struct {
        logic           sof;
        logic [GW-1:0]  din;
        int             idx;
        logic           eof;
    } vec_t;

    vec_t v[12];
    int ids[12] = '{0, 1, 4, 9, 1, 2, 5, 10, 0, 1, 0, 1};
    logic [GW-1:0] m_lut[64];
    logic [GW-1:0] m_dout, m_gout, pa, pb, nv;
    logic m_full, m_eof;
    int mx, my, px, py, k, r2;

    initial begin
        repeat (2) tick;
        reset = 0;
        check("s reset hs", 64'({s_ii, s_ir}), 64'(2'b10));
        check("s reset data", 64'(s_dout), 64'(0));
        check("s reset gain", 64'(s_gout), 64'(0));
        check("s reset eof", 64'(s_eof), 64'(0));
        check("d reset hs", 64'({d_ii, d_ir}), 64'(2'b10));
        s_push(0, 36'h123456789, UNITY, 0, "first unity");
        for (int i = 0; i <= 10; i++) begin
            s_we = 1; s_addr = 6'(i); s_ldata = s_pat(i);
            tick;
        end
        s_we = 0;
        for (int i = 0; i < 12; i++)
            v[i] = '{sof: (i == 0 || i == 10), din: {4'(i), 32'($urandom)}, idx: ids[i], eof: (i == 7)};
        for (int i = 0; i < 12; i++)
            s_push(v[i].sof, v[i].din, s_pat(v[i].idx), v[i].eof, $sformatf("vec%0d", i));
        pa = 36'hAAA_BBB_CCC;
        pb = 36'h111_222_333;
        s_ui = 1; s_din = pa;
        tick;
        check("bp accept", 64'({s_ii, s_ir}), 64'(2'b01));
        s_din = pb;
        for (int i = 0; i < 5; i++) begin
            tick;
            check($sformatf("bp hold%0d hs", i), 64'({s_ii, s_ir}), 64'(2'b01));
            check($sformatf("bp hold%0d data", i), 64'(s_dout), 64'(pa));
            check($sformatf("bp hold%0d gain", i), 64'(s_gout), 64'(s_pat(4)));
        end
        s_ui = 0; s_ur = 1;
        tick;
        check("bp release", 64'({s_ii, s_ir}), 64'(2'b10));
        tick;
        check("bp single drain", 64'({s_ii, s_ir}), 64'(2'b10));
        tick;
        s_ur = 0;
        check("stray ready", 64'({s_ii, s_ir}), 64'(2'b10));
        s_push(0, pb, s_pat(9), 0, "after bp");
        nv = 36'hFED_CBA_987;
        s_ui = 1; s_din = pa; s_we = 1; s_addr = 6'd1; s_ldata = nv;
        tick;
        s_ui = 0; s_we = 0;
        check("collide old gain", 64'(s_gout), 64'(s_pat(1)));
        s_ur = 1;
        tick;
        s_ur = 0;
        s_push(1, pb, s_pat(0), 0, "collide resync");
        s_push(0, pa, nv, 0, "collide new gain");

        d_write(0, 36'h180_100_0C0);
        d_write(39, 36'h200_1A0_190);
        d_write(62, 36'h062_062_062);
        d_write(63, 36'h063_063_063);
        d_cx = 10'd320; d_cy = 9'd240;
        d_push(36'h000_000_001, 36'h200_1A0_190, "r2 160000 idx39");
        d_cx = 10'd1; d_cy = 9'd0;
        d_push(36'h000_000_002, 36'h180_100_0C0, "centre idx0");
        d_cx = 10'd508;
        d_push(36'h000_000_003, 36'h062_062_062, "idx62");
        d_cx = 10'd639; d_cy = 9'd479;
        d_push(36'h000_000_004, 36'h063_063_063, "idx clamp63");
        d_ui = 1; d_din = 36'h555_555_555;
        tick;
        d_ui = 0;
        reset = 1;
        #2;
        check("async reset hs", 64'({d_ii, d_ir}), 64'(2'b10));
        check("async reset data", 64'(d_dout), 64'(0));
        tick;
        reset = 0;
        check("mid reset gain", 64'(d_gout), 64'(0));
        d_cx = 10'd320; d_cy = 9'd240;
        d_push(36'h000_000_005, UNITY, "table back to unity");

        for (int i = 0; i < 64; i++) m_lut[i] = UNITY;
        m_full = 0; m_dout = 36'h000_000_005; m_gout = UNITY; m_eof = 0;
        mx = 1; my = 0;
        for (int c = 0; c < 1500; c++) begin
            d_ui = $urandom_range(0, 2) != 0;
            d_ur = 1'($urandom_range(0, 1));
            d_sof = $urandom_range(0, 99) == 0;
            d_din = {4'($urandom), 32'($urandom)};
            d_cx = 10'($urandom_range(0, 639));
            d_cy = $urandom_range(0, 1) != 0 ? 9'(my) : 9'($urandom_range(0, 479));
            d_we = $urandom_range(0, 3) == 0;
            d_addr = 6'($urandom);
            d_ldata = {4'($urandom), 32'($urandom)};
            if (d_ui && !m_full) begin
                px = d_sof ? 0 : mx;
                py = d_sof ? 0 : my;
                r2 = (px - int'(d_cx)) * (px - int'(d_cx)) + (py - int'(d_cy)) * (py - int'(d_cy));
                k = r2 / 4096;
                if (k > 63) k = 63;
                m_dout = d_din;
                m_gout = m_lut[k];
                m_eof = px == 639 && py == 479;
                m_full = 1;
                mx = (px + 1) % 640;
                my = px == 639 ? (py + 1) % 480 : py;
            end else if (d_ur && m_full)
                m_full = 0;
            if (d_we) m_lut[d_addr] = d_ldata;
            tick;
            check($sformatf("rnd%0d hs", c), 64'({d_ii, d_ir}), 64'({!m_full, m_full}));
            check($sformatf("rnd%0d data", c), 64'(d_dout), 64'(m_dout));
            check($sformatf("rnd%0d gain", c), 64'(d_gout), 64'(m_gout));
            check($sformatf("rnd%0d eof", c), 64'(d_eof), 64'(m_eof));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
